// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM state and
// operation enums, default geometry, and the byte-to-word address helper.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W      = 17;
    localparam int SRAM_DATA_W      = 32;
    localparam int SRAM_BASE_ADDR   = 1024;
    localparam int SRAM_WAIT_CYCLES = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // Full 32-bit word offset of a byte address relative to the SRAM base.
    // Callers truncate to the SRAM address width or use the upper bits for
    // range checking; address[1:0] fall away in the shift.
    function automatic logic [31:0] byte_to_word_offset(input logic [31:0] address,
                                                        input logic [31:0] base_addr);
        return (address - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: level load/store requests in,
// load data, ready and range-error flag out.
interface sram_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
);

    logic              wr_en;
    logic              rd_en;
    logic [31:0]       address;
    logic [DATA_W-1:0] st_val;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              addr_err;

    // MEM stage issues requests and waits on ready.
    modport master (
        output wr_en, rd_en, address, st_val,
        input  rd_data, ready, addr_err
    );

    // Controller accepts requests and reports completion.
    modport slave (
        input  wr_en, rd_en, address, st_val,
        output rd_data, ready, addr_err
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM access: cleared when an access is
// accepted, counts while the access is on the pins, and flags the last
// wait cycle (count == WAIT_CYCLES-1).
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int              CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count wait cycles; clear takes priority over enable.
    // NOTE: flops use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/sram_controller.sv
// SRAM initiator between the MEM stage and the external SRAM pins.
// Each load/store becomes a WAIT_CYCLES-long access with address (and,
// for stores, data with SRAM_WE_N low) held on the pins, followed by a
// DONE cycle that raises ready. Store data is held one extra cycle after
// SRAM_WE_N rises. WAIT_CYCLES must be >= 2 so the half-rate SRAM clock
// sees at least one edge per access.
// Optional range check: define SRAM_CTRL_RANGE_CHECK_EN to complete
// accesses below BASE_ADDR or beyond the SRAM word space immediately
// (stores dropped, loads return 0) with addr_err pulsed in DONE. Without
// it the word address simply wraps and addr_err stays 0.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    sram_controller_if.slave  bus,
    output logic              SRAM_WE_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    state_t            state_q,   state_d;
    op_t               op_q,      op_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              we_n_q,    we_n_d;
    logic              dq_oe_q,   dq_oe_d;
    logic              err_q,     err_d;

    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_tc;

    logic              request;
    op_t               req_op;
    logic [31:0]       word_offset;
    logic [ADDR_W-1:0] req_word;
    logic              out_of_range;

    assign request     = bus.wr_en | bus.rd_en;
    assign req_op      = bus.wr_en ? OP_WR : OP_RD;   // store wins when both are raised
    assign word_offset = byte_to_word_offset(bus.address, 32'(BASE_ADDR));
    assign req_word    = word_offset[ADDR_W-1:0];

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign out_of_range = (bus.address < 32'(BASE_ADDR)) || (word_offset[31:ADDR_W] != '0);
`else
    logic unused_offset_bits;
    assign unused_offset_bits = |word_offset[31:ADDR_W];
    assign out_of_range       = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .tc     (cnt_tc)
    );

    // Next-state logic plus next values for the registered pin drivers.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        we_n_d     = 1'b1;
        dq_oe_d    = 1'b0;
        err_d      = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    cnt_clear = 1'b1;
                    op_d      = req_op;
                    data_d    = bus.st_val;
                    if (out_of_range) begin
                        // Rejected access: pins untouched, loads return zero.
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (req_op == OP_RD) begin
                            rd_data_d = '0;
                        end
                    end else begin
                        state_d = ACCESS;
                        addr_d  = req_word;
                        we_n_d  = (req_op != OP_WR);
                        dq_oe_d = (req_op == OP_WR);
                    end
                end
            end

            ACCESS: begin
                cnt_enable = 1'b1;
                we_n_d     = (op_q != OP_WR);
                dq_oe_d    = (op_q == OP_WR);
                if (cnt_tc) begin
                    // Write enable rises into DONE while store data stays on
                    // the bus for one hold cycle.
                    state_d = DONE;
                    we_n_d  = 1'b1;
                    if (op_q == OP_RD) begin
                        rd_data_d = SRAM_DQ;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pin registers; reset aborts any access and releases the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            err_q     <= err_d;
        end
    end

    assign SRAM_WE_N    = we_n_q;
    assign SRAM_ADDR    = addr_q;
    assign SRAM_DQ      = dq_oe_q ? data_q : 'z;

    assign bus.rd_data  = rd_data_q;
    assign bus.addr_err = err_q;
    assign bus.ready    = ((state_q == IDLE) && !request) || (state_q == DONE);

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the external SRAM interface, inside the ARM core, between the MEM stage and the SRAM pins (SRAM_WE_N / SRAM_ADDR / SRAM_DQ).
- Converts single-cycle MEM-stage load/store requests into multi-cycle SRAM transactions with a fixed wait-state count.
- Holds the pipeline through a ready signal until each access completes.

Parameters:
- WAIT_CYCLES, 5, number of cycles SRAM_WE_N/address are held per access; must be >= 2 so the half-rate SRAM clock sees at least one edge.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- ADDR_W, 17, SRAM word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  MEM-stage store request (level, held until ready)
- rd_en  in  1  MEM-stage load request (level, held until ready)
- address  in  32  byte address from the ALU
- st_val  in  DATA_W  store data
- rd_data  out  DATA_W  load result
- ready  out  1  access complete / no access pending; 0 freezes the pipeline
- addr_err  out  1  out-of-range access flag (see Optional Feature)
- SRAM_WE_N  out  1  SRAM write enable, active low
- SRAM_ADDR  out  ADDR_W  SRAM word address
- SRAM_DQ  inout  DATA_W  SRAM data bus

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, rd_data=0, addr_err=0, counter=0.
- Word address is (address - BASE_ADDR) >> 2, truncated to ADDR_W bits. address[1:0] are ignored.
- FSM states and transitions:
  - IDLE: on wr_en or rd_en, latch address, st_val and op, clear counter, go to ACCESS. Write has priority when both are high; a read is then not performed.
  - ACCESS: SRAM_ADDR = latched word address. On a write, SRAM_WE_N=0 and SRAM_DQ=latched data. On a read, SRAM_WE_N=1 and SRAM_DQ=Z. Counter increments each cycle. When counter==WAIT_CYCLES-1: a read samples SRAM_DQ into rd_data, then go to DONE.
  - DONE: SRAM_WE_N=1. On a write, SRAM_DQ stays driven for one hold cycle. ready=1. Go to IDLE unconditionally.
- ready = (IDLE and not (wr_en or rd_en)) or DONE. ready is combinational from state and requests.
- Latency: request seen in IDLE at cycle 0, ACCESS during cycles 1..WAIT_CYCLES, DONE/ready at cycle WAIT_CYCLES+1.
- A request still held in the cycle after DONE starts a new access; the MEM stage must have advanced.
- rd_data holds its value until the next completed read. Writes never change it.
- SRAM_ADDR holds its last value outside ACCESS.
- SRAM_DQ is driven only in ACCESS/DONE of a write; otherwise Z.
- Requests that change during ACCESS are ignored; the latched values are used.
- Reset mid-access aborts immediately: SRAM_WE_N returns to 1, DQ is released, and no partial rd_data update occurs.

Optional Feature:
- Macro: SRAM_CTRL_RANGE_CHECK_EN.
- Defined: accesses with address < BASE_ADDR or word address >= 2^ADDR_W are out of range and go IDLE -> DONE directly.
  - Out-of-range write: never drives SRAM_WE_N low; it is dropped.
  - Out-of-range read: loads rd_data=0.
  - addr_err=1 only during that DONE cycle.
- Undefined: no check. The address truncates/wraps and the access proceeds normally. addr_err is tied 0.

Decomposition:
- Shared package sram_ctrl_pkg contains:
  - state enum {IDLE, ACCESS, DONE}
  - op enum {OP_RD, OP_WR}
  - SRAM_ADDR_W=17, SRAM_DATA_W=32, SRAM_BASE_ADDR=1024 constants
- One natural sub-module: sram_wait_counter (clear/enable, terminal-count output at WAIT_CYCLES-1).

Test Plan:
- Reset held 200 ns -> SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, ready=1, rd_data=0, addr_err=0.
- wr_en=1, address=1032, st_val=0xDEADBEEF -> SRAM_ADDR=2, SRAM_WE_N=0 for cycles 1-5, DQ=0xDEADBEEF through cycle 6, ready=1 only at cycle 6.
- Then rd_en=1, address=1032 -> SRAM_WE_N stays 1, DQ=Z, rd_data=0xDEADBEEF at cycle 6, ready pulse at cycle 6.
- wr_en=rd_en=1, address=1036, st_val=0x12345678 -> write to word 3; rd_data unchanged (0xDEADBEEF).
- reset asserted at cycle 3 of a write -> SRAM_WE_N=1 and DQ=Z the same cycle, state IDLE, ready=1 after reset release.
- address=1020 write: with SRAM_CTRL_RANGE_CHECK_EN -> SRAM_WE_N never 0, ready and addr_err=1 at cycle 1. Without it -> SRAM_ADDR=0x1FFFF, normal 5-cycle write.
